// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported unified memory between the IF stage (instruction
// fetch) and the MEM stage (load/store). A two-state FSM (IDLE/BUSY) grants
// one requester at a time. The losing stage stays stalled until its own access
// completes. A bounded-wait counter aborts an access that never sees p_ack_i,
// so the pipeline cannot hang.
//
// Optional build macro: ARB_FAIR_EN
//   defined   : a starvation counter forces an IF grant after STARVE_LIM
//               consecutive MEM grants made while IF was requesting.
//   undefined : strict MEM-over-IF priority, no counter logic.
//
// Ports
//   clk_i, reset_i            clock, asynchronous active-high reset
//   if_req_i/if_addr_i        fetch request (held until if_valid_o) + address
//   if_rdata_o/if_valid_o     registered fetch data + one-cycle done pulse
//   mem_req_i/mem_we_i        load/store request (held until mem_valid_o)
//   mem_addr_i/mem_wdata_i    load/store address + store data
//   mem_rdata_o/mem_valid_o   registered load data + one-cycle done pulse
//   stall_if_o/stall_mem_o    request pending and not completing this cycle
//   p_req_o/p_we_o            memory port request / write enable
//   p_addr_o/p_wdata_o        memory port address / write data (held in IDLE)
//   p_ack_i/p_rdata_i         memory port done + read data (same cycle)
//   timeout_o                 one-cycle pulse when an access is aborted
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = 15
`ifdef ARB_FAIR_EN
  ,
  parameter int STARVE_LIM = 4
`endif
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_valid_o,
  output logic              stall_if_o,
  output logic              stall_mem_o,
  output logic              p_req_o,
  output logic              p_we_o,
  output logic [ADDR_W-1:0] p_addr_o,
  output logic [DATA_W-1:0] p_wdata_o,
  input  logic              p_ack_i,
  input  logic [DATA_W-1:0] p_rdata_i,
  output logic              timeout_o
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_MEM = 2'd2} owner_t;

  // Wait counter only has to reach MAX_WAIT-1: the abort decision is taken in
  // the MAX_WAIT-th no-ack cycle, not one cycle later.
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  owner_t              r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_if_valid;
  logic                r_mem_valid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_mem_rdata;
  logic                r_timeout;

  logic                w_if_elig;
  logic                w_mem_elig;
  logic                w_grant_if;
  logic                w_grant_mem;
  logic                w_done;
  logic                w_abort;
  logic [DATA_W-1:0]   w_rdata_ret;

`ifdef ARB_FAIR_EN
  localparam int STARVE_W = $clog2(STARVE_LIM + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);
  logic [STARVE_W-1:0] r_starve;
  logic                w_force_if;
  assign w_force_if = (r_starve == STARVE_MAX);
`endif

  // Next-state logic: arbitration in IDLE, ack/timeout resolution in BUSY.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    // A requester seeing its valid pulse this cycle is still holding the
    // request it just completed; it must not be granted again.
    w_if_elig   = if_req_i & ~r_if_valid;
    w_mem_elig  = mem_req_i & ~r_mem_valid;
    case (r_state)
      S_IDLE: begin
`ifdef ARB_FAIR_EN
        if (w_if_elig && (!w_mem_elig || w_force_if)) begin
          w_grant_if = 1'b1;
        end else if (w_mem_elig) begin
          w_grant_mem = 1'b1;
        end else begin
          w_grant_if = 1'b0;
        end
`else
        if (w_mem_elig) begin
          w_grant_mem = 1'b1;
        end else if (w_if_elig) begin
          w_grant_if = 1'b1;
        end else begin
          w_grant_mem = 1'b0;
        end
`endif
        if (w_grant_if || w_grant_mem) begin
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        // Ack takes precedence, so an ack in the last allowed cycle completes.
        if (p_ack_i) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wait == WAIT_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Stores and aborted accesses return zero data.
    if (w_done && !r_we) begin
      w_rdata_ret = p_rdata_i;
    end else begin
      w_rdata_ret = {DATA_W{1'b0}};
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Access latch, wait counter, completion pulses and returned data.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_owner     <= OWN_NONE;
      r_addr      <= {ADDR_W{1'b0}};
      r_we        <= 1'b0;
      r_wdata     <= {DATA_W{1'b0}};
      r_wait      <= {WAIT_W{1'b0}};
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_if_rdata  <= {DATA_W{1'b0}};
      r_mem_rdata <= {DATA_W{1'b0}};
      r_timeout   <= 1'b0;
    end else begin
      r_if_valid  <= (w_done | w_abort) & (r_owner == OWN_IF);
      r_mem_valid <= (w_done | w_abort) & (r_owner == OWN_MEM);
      r_timeout   <= w_abort;
      if (w_grant_mem) begin
        r_owner <= OWN_MEM;
        r_addr  <= mem_addr_i;
        r_we    <= mem_we_i;
        r_wdata <= mem_wdata_i;
        r_wait  <= {WAIT_W{1'b0}};
      end else if (w_grant_if) begin
        r_owner <= OWN_IF;
        r_addr  <= if_addr_i;
        r_we    <= 1'b0;
        r_wdata <= {DATA_W{1'b0}};
        r_wait  <= {WAIT_W{1'b0}};
      end else if (w_done || w_abort) begin
        r_owner <= OWN_NONE;
      end else if (r_state == S_BUSY) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
      if ((w_done || w_abort) && (r_owner == OWN_IF)) begin
        r_if_rdata <= w_rdata_ret;
      end
      if ((w_done || w_abort) && (r_owner == OWN_MEM)) begin
        r_mem_rdata <= w_rdata_ret;
      end
    end
  end

`ifdef ARB_FAIR_EN
  // Starvation counter: MEM grants taken while IF waits; saturates at the limit.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_starve <= {STARVE_W{1'b0}};
    end else if (w_grant_if) begin
      r_starve <= {STARVE_W{1'b0}};
    end else if (w_grant_mem && if_req_i && !w_force_if) begin
      r_starve <= r_starve + STARVE_W'(1);
    end
  end
`endif

  assign p_req_o     = (r_state == S_BUSY);
  assign p_we_o      = r_we;
  assign p_addr_o    = r_addr;
  assign p_wdata_o   = r_wdata;
  assign if_valid_o  = r_if_valid;
  assign mem_valid_o = r_mem_valid;
  assign if_rdata_o  = r_if_rdata;
  assign mem_rdata_o = r_mem_rdata;
  assign timeout_o   = r_timeout;
  assign stall_if_o  = if_req_i & ~r_if_valid;
  assign stall_mem_o = mem_req_i & ~r_mem_valid;

endmodule
